// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default line rate and bit-period derivation.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DEFAULT_CLK_HZ = 100_000_000;
    localparam int DEFAULT_BAUD   = 115200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Integer division; any fractional remainder shows up as a small per-frame drift.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: valid/ready data path plus error pulses.
interface uart_rx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    modport master (output data, output data_valid, output frame_err, output overrun,
                    input  data_ready);
    modport slave  (input  data, input  data_valid, input  frame_err, input  overrun,
                    output data_ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selectable so an
// idle-high line does not look like an edge coming out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a falling-edge start, one-deep holding
// register with valid/ready handshake, frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     rx,
    uart_rx_if.master bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic             rxs;
    logic             rxs_prev_reg;
    uart_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_reg;
    logic             data_valid_reg;
    logic             frame_err_reg;
    logic             overrun_reg;
    logic             bit_end;
    logic             capture;
    logic             stop_sample;
    logic             byte_done;
    logic             stop_low;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .srst (reset),
        .d    (rx),
        .q    (rxs)
    );

    assign bit_end = (cnt_reg == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            rxs_prev_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            rxs_prev_reg <= rxs;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        unique case (state_reg)
            // Edge detect (not level) so a line stuck low cannot restart a frame.
            ST_IDLE: begin
                if (rxs_prev_reg && !rxs) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end
            ST_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        capture     = 1'b0;
        stop_sample = 1'b0;
        case (state_reg)
            ST_DATA: capture     = bit_end;
            ST_STOP: stop_sample = bit_end;
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (capture && (idx_reg == 3'(gi))) ? rxs : shift_reg[gi];
        end
    endgenerate

    assign byte_done = stop_sample & rxs;
    assign stop_low  = stop_sample & ~rxs;

    // A completion coinciding with a consume refills the register without a gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg       <= 8'h00;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            frame_err_reg <= stop_low;
            overrun_reg   <= byte_done & data_valid_reg & ~bus.data_ready;
            if (byte_done && (!data_valid_reg || bus.data_ready)) begin
                data_reg       <= shift_reg;
                data_valid_reg <= 1'b1;
            end else if (data_valid_reg && bus.data_ready) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.data       = data_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.frame_err  = frame_err_reg;
    assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled line rate (32 clocks per bit) so every
// scenario fits in a few thousand cycles; all expected values are hand-derived.
module tb_uart_rx;
    localparam int CLK_HZ  = 3_200_000;
    localparam int BAUD    = 100_000;
    localparam int CPB     = 32;   // 3.2 MHz / 100 kBd
    localparam int LAT_NOM = 304;  // 9.5 bit periods
    localparam int GLITCH  = 14;   // ~400/868 of a bit period, shorter than half a bit

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_rx_if bus();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int         dv_cycles = 0;
    int         dv_low = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         first_dv_cyc = 0;
    int         tx_start = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] rx_q[$];

    // Observe just after the falling edge; inputs change exactly on it.
    always @(negedge clk) begin
        #1;
        if (bus.data_valid) begin
            dv_cycles++;
            if (!dv_prev) first_dv_cyc = cyc;
            if (bus.data_ready) begin
                rx_q.push_back(bus.data);
                $display("rx byte 0x%02h accepted at cycle %0d", bus.data, cyc);
            end
        end else begin
            dv_low++;
        end
        if (bus.frame_err) $display("frame_err pulse at cycle %0d", cyc);
        if (bus.overrun)   $display("overrun pulse at cycle %0d", cyc);
        if (bus.frame_err) fe_cnt++;
        if (bus.overrun)   ov_cnt++;
        dv_prev = bus.data_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        if (rx_q.size() == 0) check({tag, "_missing"}, 32'd0, 32'd1);
        else                  check(tag, rx_q.pop_front(), exp);
    endtask

    // Called on a falling edge; returns on the falling edge that ends the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        $display("tx byte 0x%02h stop=%0b at cycle %0d", b, stop_bit, cyc);
        rx = 1'b0;
        tx_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 50000 cycles, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, l0, f0, o0, lat, lat_a5;
        logic [7:0] b5a;
        bus.data_ready = 1'b0;

        repeat (4) @(negedge clk);
        check("reset_data", bus.data, 8'h00);
        check("reset_valid", bus.data_valid, 1'b0);
        check("reset_frame_err", bus.frame_err, 1'b0);
        check("reset_overrun", bus.overrun, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte, consumer always ready
        bus.data_ready = 1'b1;
        n0 = dv_cycles;
        send_byte(8'hA5, 1'b1);
        repeat (CPB) @(negedge clk);
        expect_byte("a5_data", 8'hA5);
        check("a5_valid_one_cycle", dv_cycles - n0, 1);
        lat = first_dv_cyc - tx_start;
        lat_a5 = lat;
        // lat-1 counts from the first clock edge that sees the falling start edge
        check("a5_latency_in_window", ((lat - 1 >= LAT_NOM - 3) && (lat - 1 <= LAT_NOM + 3)) ? 1 : 0, 1);

        // Back-to-back frames
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (CPB) @(negedge clk);
        check("b2b_count", rx_q.size(), 3);
        expect_byte("b2b_first", 8'h00);
        expect_byte("b2b_second", 8'hFF);
        expect_byte("b2b_third", 8'h55);
        check("b2b_no_frame_err", fe_cnt, 0);
        check("b2b_no_overrun", ov_cnt, 0);

        // Short low glitch on the idle line
        n0 = dv_cycles;
        f0 = fe_cnt;
        $display("tx glitch %0d cycles at cycle %0d", GLITCH, cyc);
        rx = 1'b0;
        repeat (GLITCH) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_valid", dv_cycles - n0, 0);
        check("glitch_no_frame_err", fe_cnt - f0, 0);
        send_byte(8'h69, 1'b1);
        repeat (CPB) @(negedge clk);
        expect_byte("after_glitch_data", 8'h69);

        // Stop bit low
        n0 = dv_cycles;
        f0 = fe_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (CPB) @(negedge clk);
        check("stop_low_frame_err_pulse", fe_cnt - f0, 1);
        check("stop_low_no_valid", dv_cycles - n0, 0);
        check("stop_low_data_held", bus.data, 8'h69);
        check("stop_low_nothing_queued", rx_q.size(), 0);

        // Holding register full, consumer stalled
        bus.data_ready = 1'b0;
        o0 = ov_cnt;
        send_byte(8'h11, 1'b1);
        repeat (CPB) @(negedge clk);
        check("hold_valid", bus.data_valid, 1'b1);
        check("hold_data", bus.data, 8'h11);
        send_byte(8'h22, 1'b1);
        repeat (CPB) @(negedge clk);
        check("overrun_pulse", ov_cnt - o0, 1);
        check("overrun_data_kept", bus.data, 8'h11);
        check("overrun_valid_kept", bus.data_valid, 1'b1);

        // Consume exactly on the completion cycle of the next byte
        o0 = ov_cnt;
        l0 = dv_low;
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (lat_a5 - 1) @(negedge clk);
                bus.data_ready = 1'b1;
                @(negedge clk);
                bus.data_ready = 1'b0;
            end
        join
        repeat (CPB) @(negedge clk);
        check("same_cycle_no_overrun", ov_cnt - o0, 0);
        check("same_cycle_valid_no_gap", dv_low - l0, 0);
        check("same_cycle_data", bus.data, 8'h22);
        expect_byte("same_cycle_consumed_old", 8'h11);

        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("consume_valid_drops", bus.data_valid, 1'b0);
        check("consume_data_holds", bus.data, 8'h22);
        expect_byte("consume_data", 8'h22);

        // Reset in the middle of bit 4 of 0x5A
        bus.data_ready = 1'b1;
        n0 = dv_cycles;
        f0 = fe_cnt;
        o0 = ov_cnt;
        b5a = 8'h5A;
        $display("tx partial byte 0x5a with reset at bit 4, cycle %0d", cyc);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b5a[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b5a[4];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_reset_data", bus.data, 8'h00);
        check("mid_reset_valid", bus.data_valid, 1'b0);
        check("mid_reset_frame_err", bus.frame_err, 1'b0);
        check("mid_reset_overrun", bus.overrun, 1'b0);
        repeat (CPB) @(negedge clk);
        reset = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("after_reset_no_valid", dv_cycles - n0, 0);
        check("after_reset_no_frame_err", fe_cnt - f0, 0);
        check("after_reset_no_overrun", ov_cnt - o0, 0);
        send_byte(8'h96, 1'b1);
        repeat (CPB) @(negedge clk);
        check("after_reset_count", rx_q.size(), 1);
        expect_byte("after_reset_data", 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
- REQ-002 Parameter BAUD, default 115200, serial bit rate.
- REQ-003 Port clk  input  1  system clock; all logic on rising edge.
- REQ-004 Port reset  input  1  synchronous, active-high reset.
- REQ-005 Port rx  input  1  asynchronous serial line; idles high; 8N1, LSB first.
- REQ-006 Port data  output  8  received byte; valid only while data_valid=1.
- REQ-007 Port data_valid  output  1  high from byte completion until consumed.
- REQ-008 Port data_ready  input  1  consumer accepts data when data_valid & data_ready.
- REQ-009 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
- REQ-010 Port overrun  output  1  one-cycle pulse: byte completed while holding register still full.

Function
- REQ-011 CLKS_PER_BIT = CLK_HZ/BAUD (integer division; 868 at defaults), HALF_BIT = CLKS_PER_BIT/2 (434).
- REQ-012 rx passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- REQ-013 FSM states: IDLE, START, DATA, STOP; one bit counter (0..CLKS_PER_BIT-1) and one 3-bit index.
- REQ-014 IDLE: on falling edge of rxs (previous 1, current 0) -> START, counter cleared; a line held low does not retrigger.
- REQ-015 START: when counter reaches HALF_BIT-1, sample rxs; 0 -> DATA (counter cleared, index 0); 1 -> IDLE (glitch rejected, no outputs).
- REQ-016 DATA: every CLKS_PER_BIT cycles sample rxs into shift register bit [index]; after index 7 -> STOP.
- REQ-017 STOP: after CLKS_PER_BIT cycles sample rxs; 1 -> byte complete; 0 -> frame_err pulse, byte discarded; either case -> IDLE.
- REQ-018 Byte complete with data_valid=0, or with data_valid=1 & data_ready=1 in the same cycle: data <= byte, data_valid <= 1 next cycle, no overrun.
- REQ-019 Byte complete with data_valid=1 & data_ready=0: byte dropped, data unchanged, overrun pulses one cycle.
- REQ-020 data_valid & data_ready with no completion: data_valid <= 0 next cycle; data holds last value.
- REQ-021 data_valid asserts 9.5*CLKS_PER_BIT cycles (+/-3 for synchronizer and registering) after the rx pin falls.
- REQ-022 data is stable while data_valid=1; data_ready is ignored while data_valid=0.
- REQ-023 Back-to-back frames (stop bit immediately followed by start bit) are received without loss.

Reset
- REQ-024 reset=1 on a rising clk edge: state IDLE, counters 0, data 8'h00, data_valid 0, frame_err 0, overrun 0, synchronizer flops 1.
- REQ-025 Reset mid-frame aborts the frame with no output pulses; reception resumes at the next falling edge after reset deasserts.

Structure
- REQ-026 Package uart_pkg holds FSM state encoding, default CLK_HZ/BAUD, and the CLKS_PER_BIT derivation, shared with uart_tx.
- REQ-027 The synchronizer is sub-module sync_2ff (1-bit, reset value parameterizable, set to 1 here).
- REQ-028 Counter width is derived from CLKS_PER_BIT (clog2); no hard-coded 10-bit width.

Verification
- REQ-029 Drive 0xA5 at 868 clk/bit, data_ready=1 -> data=0xA5, data_valid high exactly one cycle, 8246+/-3 cycles after start edge.
- REQ-030 Loopback with uart_tx sending 0x00, 0xFF, 0x55 back-to-back, data_ready=1 -> three bytes in order, no frame_err or overrun.
- REQ-031 400-cycle low glitch on idle rx -> no data_valid, no frame_err, FSM back in IDLE.
- REQ-032 Frame 0x3C with stop bit driven low -> frame_err one-cycle pulse, data_valid stays 0, data unchanged.
- REQ-033 data_ready=0, send 0x11 then 0x22 -> data=0x11 held, overrun pulse at second completion; with data_ready=1 on the completion cycle -> data=0x22, no overrun.
- REQ-034 Assert reset at bit 4 of 0x5A, release, send 0x96 -> only 0x96 reported, outputs at reset values during reset.
